printf_arbiter: RTL and testbench

Shares one debug character channel among several requesters. Each requester hands over a single data word per transaction. The block picks one requester per message by round-robin and serializes the captured word as ASCII binary digits, MSB first, followed by a newline. This is the hardware equivalent of a `"%b\n"` print record. It sits between the simulation-visible print sources and the console byte sink.

---
 rtl/printf_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/printf_arbiter.sv | 108 ++++++++++
 tb/tb_printf_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/printf_pkg.sv
// rtl/printf_pkg.sv - shared constants and state encoding for the printf arbiter
package printf_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_1  = 8'h31;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1,
        NEWLINE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     any_req
);

    localparam int GW = $clog2(N_REQ);

    int   idx;
    logic found;

    // Scan upward from last_grant+1 with wrap; the first valid index wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (req[idx] && !found) begin
                found     = 1'b1;
                grant_idx = GW'(idx);
            end
        end
        if (found) begin
            grant = N_REQ'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/printf_arbiter.sv
// rtl/printf_arbiter.sv - round-robin capture of one word, printed as "%b\n" characters
module printf_arbiter
    import printf_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      chr_valid,
    output logic [7:0]                chr_bits,
    input  logic                      chr_ready,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [GW-1:0]       last_q, last_d;
    logic [GW-1:0]       gid_q, gid_d;

    logic [N_REQ-1:0]    arb_grant;
    logic [GW-1:0]       arb_idx;
    logic                arb_any;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any_req    (arb_any)
    );

    // State registers; last grant resets to N_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            last_q  <= GW'(N_REQ - 1);
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
        end
    end

    // Next-state and outputs: capture in IDLE, one digit per accepted char, then newline.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gid_d     = gid_q;
        req_ready = '0;
        chr_valid = 1'b0;
        chr_bits  = 8'h00;
        case (state_q)
            IDLE: begin
                // Gated by reset so no accept strobe is seen while the flops are held.
                if (arb_any && !reset) begin
                    req_ready = arb_grant;
                    shift_d   = req_data[int'(arb_idx)*DATA_W +: DATA_W];
                    cnt_d     = CW'(DATA_W - 1);
                    gid_d     = arb_idx;
                    last_d    = arb_idx;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                chr_valid = 1'b1;
                chr_bits  = shift_q[DATA_W-1] ? ASCII_1 : ASCII_0;
                if (chr_ready) begin
                    shift_d = shift_q << 1;
                    if (cnt_q == '0) begin
                        state_d = NEWLINE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            NEWLINE: begin
                chr_valid = 1'b1;
                chr_bits  = ASCII_LF;
                if (chr_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign grant_id = gid_q;

endmodule

// File: tb/tb_printf_arbiter.sv
// tb/tb_printf_arbiter.sv - self-checking bench for printf_arbiter
module tb_printf_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int GW = $clog2(N);

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        req_valid;
    logic [N*DW-1:0]     req_data;
    logic [N-1:0]        req_ready;
    logic                chr_valid;
    logic [7:0]          chr_bits;
    logic                chr_ready;
    logic                busy;
    logic [GW-1:0]       grant_id;

    logic [DW-1:0]       data_arr [N];

    int passed = 0;
    int total  = 0;
    int last_g;

    printf_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .chr_valid (chr_valid),
        .chr_bits  (chr_bits),
        .chr_ready (chr_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = data_arr[i];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        total++;
        assert (obs == exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first valid index after the last capture, wrapping.
    function automatic int pick(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last_g + k) % N]) return (last_g + k) % N;
        end
        return -1;
    endfunction

    // One IDLE decision plus, if a capture happens, the whole message.
    // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
    task automatic run_msg(input int mode, input bit zap0, input bit drop_winner, output int obs_gid);
        int            w, cyc, tog;
        string         got, exp_s;
        logic [DW-1:0] word;
        logic [N-1:0]  oh;
        logic [7:0]    held;
        bit            done, stalled, ready_ok, valid_ok, gid_ok, stable_ok;
        obs_gid = -1;
        w = pick(req_valid);
        #1;
        chk("idle_chr_valid", chr_valid, 0);
        if (w < 0) begin
            chk("no_req_ready", req_ready, 0);
            @(negedge clk);
            return;
        end
        oh = '0;
        oh[w] = 1'b1;
        chk("req_ready_onehot", req_ready, oh);
        word   = data_arr[w];
        exp_s  = $sformatf("%b\n", word);
        last_g = w;
        @(negedge clk);
        obs_gid = int'(grant_id);
        if (drop_winner) req_valid[w] = 1'b0;
        if (zap0 && w == 0) data_arr[0] = '0;
        got = ""; cyc = 0; tog = 0; done = 0; stalled = 0; held = 8'h00;
        ready_ok = 1; valid_ok = 1; gid_ok = 1; stable_ok = 1;
        while (!done && cyc < 400) begin
            case (mode)
                0:       chr_ready = 1'b1;
                1:       chr_ready = (tog % 3 == 0);
                default: chr_ready = 1'($urandom_range(0, 1));
            endcase
            tog++;
            #1;
            if (req_ready !== '0) ready_ok = 0;
            if (chr_valid !== 1'b1) valid_ok = 0;
            if (int'(grant_id) != w) gid_ok = 0;
            if (stalled && chr_bits !== held) stable_ok = 0;
            if (chr_ready) begin
                got = $sformatf("%s%c", got, chr_bits);
                if (chr_bits == 8'h0A) done = 1;
                stalled = 0;
            end else begin
                stalled = 1;
                held = chr_bits;
            end
            cyc++;
            @(negedge clk);
        end
        chk("msg_done", done, 1);
        chk_str("msg_text", got, exp_s);
        chk("ready_low_in_msg", ready_ok, 1);
        chk("chr_valid_in_msg", valid_ok, 1);
        chk("grant_id_stable", gid_ok, 1);
        chk("stall_stable", stable_ok, 1);
        if (mode == 0) chk("msg_cycles", cyc, DW + 1);
    endtask

    initial begin
        int g, seen, order_ok;
        reset     = 1'b1;
        req_valid = '0;
        chr_ready = 1'b0;
        for (int i = 0; i < N; i++) data_arr[i] = '0;
        last_g = N - 1;

        // Reset values
        @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_chr_valid", chr_valid, 0);
        chk("rst_chr_bits", chr_bits, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        @(negedge clk);
        reset = 1'b0;
        chr_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (chr_valid || busy || (req_ready != 0)) seen++;
            @(negedge clk);
        end
        chk("idle_20_quiet", seen, 0);

        // Single message from requester 2
        req_valid = 4'b0100;
        data_arr[2] = 8'hA5;
        run_msg(0, 0, 1, g);
        chk("single_gid", g, 2);

        // Backpressure, ready 1,0,0,...
        req_valid = 4'b0010;
        data_arr[1] = 8'h96;
        run_msg(1, 0, 1, g);
        chk("bp_gid", g, 1);

        // req_data changes after capture must not matter
        req_valid = 4'b0001;
        data_arr[0] = 8'hFF;
        run_msg(0, 1, 1, g);
        chk("zap_gid", g, 0);

        // Round-robin with all requesters held valid; last capture was 0
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) data_arr[i] = DW'(i + 1);
        order_ok = 1;
        for (int k = 0; k < 5; k++) begin
            run_msg(0, 0, 0, g);
            if (g != (k + 1) % N) order_ok = 0;
        end
        chk("rr_order", order_ok, 1);

        // Randomized requests, data and backpressure
        for (int it = 0; it < 16; it++) begin
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) data_arr[i] = DW'($urandom);
            run_msg(1 + (it % 2), 0, $urandom_range(0, 1), g);
        end

        // Mid-message reset
        req_valid = 4'b0100;
        data_arr[2] = 8'h3C;
        chr_ready = 1'b1;
        run_to_reset();
        chk("mid_rst_chr_valid", chr_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gid", grant_id, 0);
        chk("mid_rst_chr_bits", chr_bits, 0);
        @(negedge clk);
        reset = 1'b0;
        last_g = N - 1;
        req_valid = 4'b1111;
        data_arr[0] = 8'hC3;
        run_msg(0, 0, 1, g);
        chk("post_rst_gid", g, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Capture requester 2's word, let three characters go, then assert reset.
    task automatic run_to_reset();
        #1;
        chk("pre_rst_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_fourth_char", chr_bits, 8'h31);
        reset = 1'b1;
        #1;
    endtask

endmodule
